t_ff_bank: RTL and testbench

- Parametrised successor to the single-bit toggle flip-flop: a WIDTH-bit bank of T flip-flops with a run-time mode select.
- Modes: per-bit toggle, synchronous modulo up-count, down-count, parallel load.
- Registered terminal-count pulse for cascading or clock-enable generation.
- Used as the general toggle/counter primitive in the team's small sequential datapaths.

---
 rtl/t_ff_bank.sv | 118 +++++++++++
 tb/tb_t_ff_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/t_ff_bank.sv
// -----------------------------------------------------------------------------
// t_ff_bank
//   WIDTH-bit bank of T flip-flops with a run-time mode select. It can toggle
//   individual bits, count up or down modulo MOD_MAX+1, or load a value. It
//   also produces a registered terminal-count pulse, which can be used for
//   cascading counters or for generating clock enables.
//
// Parameters
//   WIDTH    number of flip-flops (1..32)
//   MOD_MAX  highest count value in the count modes (1..2**WIDTH-1)
//   RST_VAL  reset value of q (<= MOD_MAX)
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous reset, active low
//   en    in   global enable; when low, q holds and tc returns to 0
//   mode  in   00 TOGGLE, 01 UP, 10 DOWN, 11 LOAD
//   t     in   per-bit toggle mask (TOGGLE only)
//   d     in   parallel load data (LOAD only; clamped to MOD_MAX)
//   q     out  bank state
//   tc    out  registered terminal-count pulse
//   zero  out  combinational q == 0
//
// Build option
//   TFF_BANK_SAT_EN  when defined, UP and DOWN saturate at MOD_MAX and 0
//                    instead of wrapping. tc is high on every cycle in which
//                    the step is blocked.
// -----------------------------------------------------------------------------
module t_ff_bank #(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] MOD_MAX = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic [WIDTH-1:0] w_q_next;
  logic             w_tc_next;

  always_comb begin
    // NOTE: every output of this block gets a default first. Any path that
    // does not assign a signal therefore keeps the default, and no latch is
    // inferred.
    w_q_next  = r_q;
    w_tc_next = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_TOGGLE: w_q_next = r_q ^ t;
        MODE_UP: begin
          // ">=" rather than "==" so that a value above MOD_MAX, reached by
          // toggling, still re-enters the count range on the next step.
          if (r_q >= MOD_MAX) begin
`ifdef TFF_BANK_SAT_EN
            w_q_next = MOD_MAX;
`else
            w_q_next = '0;
`endif
            w_tc_next = 1'b1;
          end else begin
            w_q_next = r_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (r_q == '0) begin
`ifdef TFF_BANK_SAT_EN
            w_q_next = '0;
`else
            w_q_next = MOD_MAX;
`endif
            w_tc_next = 1'b1;
          end else if (r_q > MOD_MAX) begin
            // Coming back into range from above is not a wrap, so tc stays 0.
            w_q_next = MOD_MAX;
          end else begin
            w_q_next = r_q - 1'b1;
          end
        end
        MODE_LOAD: w_q_next = (d > MOD_MAX) ? MOD_MAX : d;
        default:   w_q_next = r_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q  <= RST_VAL;
      r_tc <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments. All flops then
      // update together from values sampled before the edge, and reads in
      // other processes cannot race with these writes.
      r_q  <= w_q_next;
      r_tc <= w_tc_next;
    end
  end

  assign q    = r_q;
  assign tc   = r_tc;
  assign zero = (r_q == '0);

endmodule

// File: tb/tb_t_ff_bank.sv
// -----------------------------------------------------------------------------
// tb_t_ff_bank
//   Bench for t_ff_bank with WIDTH=4, MOD_MAX=9 and RST_VAL=3. It applies a
//   table of directed vectors and hand-written asynchronous-reset sequences,
//   then randomized traffic checked against an arithmetic reference model.
//   Expectations follow TFF_BANK_SAT_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_t_ff_bank;

  localparam int W  = 4;
  localparam int MM = 9;
  localparam int RV = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] t;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         tc;
  logic         zero;

  int vec_count  = 0;
  int miscompare = 0;

  // Reference model state.
  int m_q;
  bit m_tc;

  typedef struct {
    string        name;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] t;
    logic [W-1:0] d;
    int           exp_q;
    bit           exp_tc;
  } vec_t;

  vec_t tbl[$];

  t_ff_bank #(
    .WIDTH  (W),
    .MOD_MAX(4'(MM)),
    .RST_VAL(4'(RV))
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .mode(mode),
    .t   (t),
    .d   (d),
    .q   (q),
    .tc  (tc),
    .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    vec_count++;
    if (act != exp) begin
      miscompare++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string nm, input int exp_q, input bit exp_tc);
    check({nm, ".q"},    int'(q),    exp_q);
    check({nm, ".tc"},   int'(tc),   int'(exp_tc));
    check({nm, ".zero"}, int'(zero), (exp_q == 0) ? 1 : 0);
  endtask

  task automatic add(input string nm, input logic e, input logic [1:0] m,
                     input logic [W-1:0] tt, input logic [W-1:0] dd,
                     input int eq, input bit etc);
    vec_t v;
    v.name = nm; v.en = e; v.mode = m; v.t = tt; v.d = dd;
    v.exp_q = eq; v.exp_tc = etc;
    tbl.push_back(v);
  endtask

  // Drive inputs 1 ns after an edge, then sample 1 ns after the next edge.
  task automatic step(input logic e, input logic [1:0] m,
                      input logic [W-1:0] tt, input logic [W-1:0] dd);
    en = e; mode = m; t = tt; d = dd;
    @(posedge clk);
    #1;
  endtask

  // The model is written from the mode rules using plain integer arithmetic.
  function automatic void model_step(input logic e, input logic [1:0] m,
                                     input logic [W-1:0] tt,
                                     input logic [W-1:0] dd);
    int nq;
    bit ntc;
    nq  = m_q;
    ntc = 1'b0;
    if (e) begin
      case (m)
        2'd0: nq = m_q ^ int'(tt);
        2'd1: begin
`ifdef TFF_BANK_SAT_EN
          if (m_q >= MM) begin nq = MM; ntc = 1'b1; end
          else nq = m_q + 1;
`else
          if (m_q > MM) begin nq = 0; ntc = 1'b1; end
          else begin
            nq  = (m_q + 1) % (MM + 1);
            ntc = (nq == 0);
          end
`endif
        end
        2'd2: begin
          if (m_q > MM) nq = MM;
`ifdef TFF_BANK_SAT_EN
          else if (m_q == 0) begin nq = 0; ntc = 1'b1; end
`else
          else if (m_q == 0) begin nq = MM; ntc = 1'b1; end
`endif
          else nq = m_q - 1;
        end
        default: nq = (int'(dd) > MM) ? MM : int'(dd);
      endcase
    end
    m_q  = nq;
    m_tc = ntc;
  endfunction

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; t = '0; d = '0;

    // Asynchronous reset applied between edges, before any clock edge.
    #1 rst = 1'b0;
    #1 check_all("rst_async", RV, 1'b0);
    @(posedge clk); #1;
    check_all("rst_held", RV, 1'b0);
    rst = 1'b1;
    step(1'b1, 2'd1, '0, '0);
    check_all("rst_release_up", RV + 1, 1'b0);

    // Directed table.
`ifdef TFF_BANK_SAT_EN
    add("ld8",       1, 2'd3, 4'h0, 4'd8, 8, 0);
    add("sat_up1",   1, 2'd1, 4'h0, 4'h0, 9, 0);
    add("sat_up2",   1, 2'd1, 4'h0, 4'h0, 9, 1);
    add("sat_up3",   1, 2'd1, 4'h0, 4'h0, 9, 1);
    add("ld0",       1, 2'd3, 4'h0, 4'd0, 0, 0);
    add("sat_dn1",   1, 2'd2, 4'h0, 4'h0, 0, 1);
    add("sat_dn2",   1, 2'd2, 4'h0, 4'h0, 0, 1);
    add("tog_f",     1, 2'd0, 4'hF, 4'h0, 15, 0);
    add("sat_up_hi", 1, 2'd1, 4'h0, 4'h0, 9, 1);
    add("tog_6",     1, 2'd0, 4'h6, 4'h0, 15, 0);
    add("dn_hi",     1, 2'd2, 4'h0, 4'h0, 9, 0);
    add("dn_9",      1, 2'd2, 4'h0, 4'h0, 8, 0);
`else
    add("ld8",       1, 2'd3, 4'h0, 4'd8, 8, 0);
    add("up_9",      1, 2'd1, 4'h0, 4'h0, 9, 0);
    add("up_wrap",   1, 2'd1, 4'h0, 4'h0, 0, 1);
    add("up_1",      1, 2'd1, 4'h0, 4'h0, 1, 0);
    add("dn_0",      1, 2'd2, 4'h0, 4'h0, 0, 0);
    add("dn_wrap",   1, 2'd2, 4'h0, 4'h0, 9, 1);
    add("dn_8",      1, 2'd2, 4'h0, 4'h0, 8, 0);
    add("ld5",       1, 2'd3, 4'h0, 4'd5, 5, 0);
    add("tog_c",     1, 2'd0, 4'hC, 4'h0, 9, 0);
    add("ld14_clmp", 1, 2'd3, 4'h0, 4'd14, 9, 0);
    add("ld6",       1, 2'd3, 4'h0, 4'd6, 6, 0);
    add("ld9",       1, 2'd3, 4'h0, 4'd9, 9, 0);
    add("up_wrap2",  1, 2'd1, 4'h0, 4'h0, 0, 1);
    for (int i = 0; i < 4; i++) add("en0_hold", 0, 2'd1, 4'hF, 4'hF, 0, 0);
    add("tog_f",     1, 2'd0, 4'hF, 4'h0, 15, 0);
    add("up_hi",     1, 2'd1, 4'h0, 4'h0, 0, 1);
    add("tog_f2",    1, 2'd0, 4'hF, 4'h0, 15, 0);
    add("dn_hi",     1, 2'd2, 4'h0, 4'h0, 9, 0);
    add("tog_0",     1, 2'd0, 4'h0, 4'h0, 9, 0);
    add("en0_ld",    0, 2'd3, 4'h0, 4'd2, 9, 0);
`endif
    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].mode, tbl[i].t, tbl[i].d);
      check_all(tbl[i].name, tbl[i].exp_q, tbl[i].exp_tc);
    end

    // Reset on the cycle after a terminal count clears tc at once and
    // discards the count.
    step(1'b1, 2'd3, '0, 4'd9);
    check_all("pre_rst_ld9", 9, 1'b0);
    step(1'b1, 2'd1, '0, '0);
`ifdef TFF_BANK_SAT_EN
    check_all("pre_rst_tc", 9, 1'b1);
`else
    check_all("pre_rst_tc", 0, 1'b1);
`endif
    #2 rst = 1'b0;
    #1 check_all("rst_mid_count", RV, 1'b0);
    rst = 1'b1;
    m_q = RV; m_tc = 1'b0;

    // Randomized traffic against the model, with occasional async resets.
    for (int n = 0; n < 400; n++) begin
      logic         e;
      logic [1:0]   m;
      logic [W-1:0] tt, dd;
      e  = ($urandom_range(0, 7) != 0);
      m  = 2'($urandom_range(0, 3));
      tt = 4'($urandom_range(0, 15));
      dd = 4'($urandom_range(0, 15));
      step(e, m, tt, dd);
      model_step(e, m, tt, dd);
      check_all("rand", m_q, m_tc);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        #1 check_all("rand_rst", RV, 1'b0);
        rst = 1'b1;
        m_q = RV; m_tc = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare);
    $finish;
  end

endmodule
